// File: rtl/btn_debouncer.sv
// Push-button debouncer driven by a slow sample clock treated as data.
// Produces a qualified level plus press, release and auto-repeat strobes.
module btn_debouncer #(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned HOLD_SAMPLES   = 64,
    parameter int unsigned REPEAT_SAMPLES = 16,
    parameter bit          REPEAT_EN      = 1'b1,
    parameter bit          BTN_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_clk,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

    localparam logic [CNT_W-1:0] STABLE_N    = CNT_W'(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] HOLD_N      = CNT_W'(HOLD_SAMPLES);
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_SAMPLES - REPEAT_SAMPLES);

    logic             r_btn_s1, r_btn_s2;
    logic             r_sc_s1, r_sc_s2, r_sc_s3;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_stable_cnt, r_hold_cnt;
    logic             r_btn_level, r_press, r_release, r_repeat;

    logic             w_sample, w_tick;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_stable_nxt, w_hold_nxt, w_stable_inc, w_hold_inc;
    logic             w_level_nxt, w_press_nxt, w_release_nxt, w_repeat_nxt;

    assign w_sample     = r_btn_s2 ^ BTN_ACTIVE_LOW;
    assign w_tick       = r_sc_s2 & ~r_sc_s3;
    assign w_stable_inc = r_stable_cnt + CNT_W'(1);
    assign w_hold_inc   = r_hold_cnt + CNT_W'(1);

    // Input synchronisers for the button pin and the sample clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_sc_s1  <= 1'b0;
            r_sc_s2  <= 1'b0;
            r_sc_s3  <= 1'b0;
        end else begin
            r_btn_s1 <= btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sc_s1  <= sample_clk;
            r_sc_s2  <= r_sc_s1;
            r_sc_s3  <= r_sc_s2;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RELEASED;
            r_stable_cnt <= '0;
            r_hold_cnt   <= '0;
            r_btn_level  <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_repeat     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stable_cnt <= w_stable_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_btn_level  <= w_level_nxt;
            r_press      <= w_press_nxt;
            r_release    <= w_release_nxt;
            r_repeat     <= w_repeat_nxt;
        end
    end

    // Next-state logic; nothing moves except on a sample tick
    always_comb begin
        w_state_nxt   = r_state;
        w_stable_nxt  = r_stable_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_RELEASED: begin
                    if (w_sample) begin
                        if (STABLE_SAMPLES == 32'd1) begin
                            w_state_nxt  = ST_PRESSED;
                            w_stable_nxt = '0;
                            w_hold_nxt   = '0;
                            w_press_nxt  = 1'b1;
                        end else begin
                            w_state_nxt  = ST_PRESS_PEND;
                            w_stable_nxt = CNT_W'(1);
                        end
                    end
                end
                ST_PRESS_PEND: begin
                    if (!w_sample) begin
                        w_state_nxt  = ST_RELEASED;
                        w_stable_nxt = '0;
                    end else if (w_stable_inc == STABLE_N) begin
                        w_state_nxt  = ST_PRESSED;
                        w_stable_nxt = '0;
                        w_hold_nxt   = '0;
                        w_press_nxt  = 1'b1;
                    end else begin
                        w_stable_nxt = w_stable_inc;
                    end
                end
                ST_PRESSED: begin
                    if (w_sample) begin
                        // Reload keeps hold_cnt below HOLD_SAMPLES so it never wraps
                        if (w_hold_inc == HOLD_N) begin
                            w_hold_nxt   = HOLD_RELOAD;
                            w_repeat_nxt = REPEAT_EN;
                        end else begin
                            w_hold_nxt = w_hold_inc;
                        end
                    end else if (STABLE_SAMPLES == 32'd1) begin
                        w_state_nxt   = ST_RELEASED;
                        w_stable_nxt  = '0;
                        w_hold_nxt    = '0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_RELEASE_PEND;
                        w_stable_nxt = CNT_W'(1);
                    end
                end
                ST_RELEASE_PEND: begin
                    if (w_sample) begin
                        w_state_nxt  = ST_PRESSED;
                        w_stable_nxt = '0;
                    end else if (w_stable_inc == STABLE_N) begin
                        w_state_nxt   = ST_RELEASED;
                        w_stable_nxt  = '0;
                        w_hold_nxt    = '0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_stable_nxt = w_stable_inc;
                    end
                end
                default: begin
                    w_state_nxt  = ST_RELEASED;
                    w_stable_nxt = '0;
                    w_hold_nxt   = '0;
                end
            endcase
        end
        w_level_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_PEND);
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign repeat_pulse  = r_repeat;

endmodule

// File: tb/tb_btn_debouncer.sv
// Scoreboard bench for btn_debouncer: a run-length reference model predicts
// strobes and levels per sample tick; a monitor compares what the DUTs present.
module tb_btn_debouncer;

    localparam int unsigned STABLE = 4;
    localparam int unsigned HOLD   = 64;
    localparam int unsigned REP    = 16;

    logic clk = 1'b0;
    logic rst_n, sample_clk, btn_raw;
    logic btn_level, press_pulse, release_pulse, repeat_pulse;
    logic nr_level, nr_press, nr_release, nr_repeat;

    always #5 clk = ~clk;

    btn_debouncer #(
        .STABLE_SAMPLES(STABLE), .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP),
        .REPEAT_EN(1'b1), .BTN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .btn_raw(btn_raw),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    btn_debouncer #(
        .STABLE_SAMPLES(STABLE), .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP),
        .REPEAT_EN(1'b0), .BTN_ACTIVE_LOW(1'b0)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .btn_raw(btn_raw),
        .btn_level(nr_level), .press_pulse(nr_press),
        .release_pulse(nr_release), .repeat_pulse(nr_repeat)
    );

    typedef struct { int cyc; logic [2:0] kind; } ev_t;   // kind = {press, release, repeat}
    typedef struct { int cyc; logic lvl; } lv_t;

    ev_t  ev_q[$];
    lv_t  lv_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rep_seen = 0;
    int   nr_rep_seen = 0;
    logic m_level;
    int   m_run, m_hold;
    logic [2:0] mon_v, mon_w;
    logic prev_s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: count samples that disagree with the accepted level
    task automatic model_tick(input logic s, input int c);
        if (s != m_level) begin
            m_run++;
            if (m_run == int'(STABLE)) begin
                m_level = s;
                m_run   = 0;
                m_hold  = 0;
                ev_q.push_back('{c, s ? 3'b100 : 3'b010});
            end
        end else if (m_run != 0) begin
            m_run = 0;
        end else if (m_level) begin
            m_hold++;
            if (m_hold == int'(HOLD)) begin
                ev_q.push_back('{c, 3'b001});
                m_hold = int'(HOLD - REP);
            end
        end
        lv_q.push_back('{c, m_level});
    endtask

    // One 40-clk sample period; the DUT acts on the 3rd clk after the rise
    task automatic do_tick(input logic s);
        btn_raw = s;
        repeat (20) @(negedge clk);
        sample_clk = 1'b1;
        model_tick(s, cyc + 3);
        repeat (20) @(negedge clk);
        sample_clk = 1'b0;
    endtask

    task automatic ticks(input logic s, input int n);
        for (int i = 0; i < n; i++) do_tick(s);
    endtask

    // Monitor: pops expectations whenever the DUTs present strobes or a level is due
    always @(negedge clk) begin
        mon_v = {press_pulse, release_pulse, repeat_pulse};
        mon_w = {nr_press, nr_release, nr_repeat};
        if (repeat_pulse) rep_seen++;
        if (nr_repeat) nr_rep_seen++;
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe: got none expected kind %b at cycle %0d",
                     ev_q[0].kind, ev_q[0].cyc);
            void'(ev_q.pop_front());
        end
        if ((mon_v | mon_w) != 3'b000) begin
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                chk("strobe_kind", int'(mon_v), int'(ev_q[0].kind));
                chk("strobe_kind_norepeat", int'(mon_w), int'({ev_q[0].kind[2:1], 1'b0}));
                void'(ev_q.pop_front());
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %b/%b expected 000 at cycle %0d",
                         mon_v, mon_w, cyc);
            end
        end
        while (lv_q.size() > 0 && lv_q[0].cyc <= cyc) begin
            chk("btn_level", int'(btn_level), int'(lv_q[0].lvl));
            chk("btn_level_norepeat", int'(nr_level), int'(lv_q[0].lvl));
            void'(lv_q.pop_front());
        end
    end

    initial begin
        rst_n      = 1'b0;
        sample_clk = 1'b0;
        btn_raw    = 1'b0;
        m_level    = 1'b0;
        m_run      = 0;
        m_hold     = 0;
        repeat (5) @(negedge clk);
        chk("reset_outputs", int'(mon_v), 0);
        chk("reset_level", int'(btn_level), 0);
        chk("reset_outputs_norepeat", int'({nr_level, nr_press, nr_release, nr_repeat}), 0);
        rst_n = 1'b1;

        // Idle, clean press, clean release
        ticks(1'b0, 3);
        ticks(1'b1, 10);
        ticks(1'b0, 6);

        // Bounce on press, then hold long enough for four repeats
        do_tick(1'b1); do_tick(1'b1); do_tick(1'b0);
        ticks(1'b1, 4);
        ticks(1'b1, 64 + 16 * 3);
        chk("repeat_count", rep_seen, 4);
        chk("repeat_count_disabled", nr_rep_seen, 0);

        // Release with a one-sample glitch
        do_tick(1'b0); do_tick(1'b0); do_tick(1'b1);
        ticks(1'b0, 4);
        ticks(1'b0, 2);

        // Divider stalled while pressed: pin chatters, nothing may change
        ticks(1'b1, 5);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            btn_raw = 1'($urandom_range(0, 1));
        end
        lv_q.push_back('{cyc + 1, m_level});
        ticks(1'b1, 2);

        // Asynchronous reset while pressed, button still held afterwards
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_level", int'(btn_level), 0);
        chk("async_reset_level_norepeat", int'(nr_level), 0);
        m_level = 1'b0;
        m_run   = 0;
        m_hold  = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ticks(1'b1, 6);
        ticks(1'b0, 5);

        // Random sticky stimulus
        prev_s = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 25) prev_s = ~prev_s;
            do_tick(prev_s);
        end

        repeat (10) @(negedge clk);
        chk("events_drained", ev_q.size(), 0);
        chk("levels_drained", lv_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
